stepper_drive: RTL and testbench
================================

STEPPER_DRIVE -- requirements
Module: stepper_drive

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of step-period divider.
REQ-002 SHALL have parameter POS_W, default 16, width of position and move-length counters.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port run  input  1  level, jog motor while high (IDLE/JOG only).
REQ-006 SHALL have port dir  input  1  1 = forward (phase up), 0 = reverse (phase down).
REQ-007 SHALL have port mode  input  2  00 half-step, 01 full-step two-phase, 10 wave, 11 treated as half-step.
REQ-008 SHALL have port period  input  DIV_W  clocks per step; 0 treated as 1.
REQ-009 SHALL have port energize  input  1  0 forces motor to 4'b0000 (coils off).
REQ-010 SHALL have port move_start  input  1  single-cycle pulse, start counted move.
REQ-011 SHALL have port move_steps  input  POS_W  step count, sampled on accepted move_start.
REQ-012 SHALL have port abort  input  1  level, stop any motion.
REQ-013 SHALL have port motor  output  4  registered coil drive.
REQ-014 SHALL have port position  output  POS_W  signed step count, two's complement.
REQ-015 SHALL have port busy  output  1  high in MOVE state.
REQ-016 SHALL have port done  output  1  one-cycle pulse on move completion.

Function
REQ-017 SHALL keep a 3-bit phase index with table 0:1000 1:1100 2:0100 3:0110 4:0010 5:0011 6:0001 7:1001.
REQ-018 SHALL register motor = energize ? table(phase) : 4'b0000, one clock after any phase or energize change.
REQ-019 SHALL implement states IDLE, JOG, MOVE.
REQ-020 IDLE->JOG when run=1 and abort=0; JOG->IDLE when run=0 or abort=1.
REQ-021 IDLE->MOVE on move_start=1, abort=0, move_steps!=0; latch move_steps as remaining count.
REQ-022 move_start in IDLE with move_steps=0 SHALL pulse done next cycle, no step, stay IDLE.
REQ-023 move_start in JOG or MOVE SHALL be ignored; run SHALL be ignored in MOVE.
REQ-024 In JOG/MOVE a divider SHALL issue one step every max(period,1) clocks; first step max(period,1) clocks after state entry; divider cleared on entry to IDLE.
REQ-025 period and mode changes SHALL take effect at next divider reload / next step.
REQ-026 Step, half mode: phase += ±1 (mod 8, wrap 7<->0).
REQ-027 Step, full mode: phase += ±2 if phase odd, else ±1 (aligns to odd).
REQ-028 Step, wave mode: phase += ±2 if phase even, else ±1 (aligns to even).
REQ-029 Each step SHALL add +1 (dir=1) or -1 (dir=0) to position, wrapping modulo 2^POS_W.
REQ-030 dir SHALL be sampled at each step, not latched at start.
REQ-031 In MOVE each step SHALL decrement remaining; on step leaving remaining=0, return to IDLE and pulse done the following cycle.
REQ-032 abort=1 SHALL return to IDLE next cycle from any state, no step that cycle, no done pulse; phase and position held.
REQ-033 busy SHALL be 1 exactly while in MOVE.
REQ-034 Leaving motion SHALL hold phase (holding torque when energize=1).

Reset
REQ-035 On rst=1, immediately: state IDLE, phase 0, position 0, remaining 0, divider 0, motor 4'b0000, busy 0, done 0.
REQ-036 rst asserted mid-move SHALL cancel the move with no done pulse; after release, motor = 4'b1000 one cycle after first clock if energize=1.

Verification
REQ-037 Half mode, period=4, dir=1, run high 32 clocks from reset -> 8 steps, phase 0..7..0 wrap, motor 1000,1100,...,1001,1000, position=8.
REQ-038 Full mode from phase 0, dir=0, move_steps=3, period=2 -> phases 7,5,3, position=-3, busy high 6 clocks, done single pulse after last step.
REQ-039 Wave mode from phase 3, dir=1, move_steps=2 -> phases 4,6, motor 0010 then 0001.
REQ-040 move_steps=5, abort at second step -> IDLE next cycle, position=+2, no done, busy low.
REQ-041 move_start with move_steps=0 -> done pulse next cycle, busy stays 0; period=0 -> step every clock.
REQ-042 energize=0 during jog -> motor 0000 while phase/position still advance; rst mid-move -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/stepper_drive.sv
// Stepper motor sequencer: jog or counted moves over an 8-entry half-step coil
// table, with a programmable step-period divider and signed position tracking.
module stepper_drive #(
  parameter int DIV_W = 16,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  input  logic             energize,
  input  logic             move_start,
  input  logic [POS_W-1:0] move_steps,
  input  logic             abort,
  output logic [3:0]       motor,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, JOG, MOVE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       motor_q, motor_d;
  logic             done_q, done_d;

  logic             step;
  logic [2:0]       delta;
  logic [DIV_W-1:0] reload;

  function automatic logic [3:0] coil(input logic [2:0] ph);
    case (ph)
      3'd0:    coil = 4'b1000;
      3'd1:    coil = 4'b1100;
      3'd2:    coil = 4'b0100;
      3'd3:    coil = 4'b0110;
      3'd4:    coil = 4'b0010;
      3'd5:    coil = 4'b0011;
      3'd6:    coil = 4'b0001;
      default: coil = 4'b1001;
    endcase
  endfunction

  // Divider counts down to zero; a step fires on the zero cycle, so loading
  // period-1 gives exactly max(period,1) clocks between steps.
  assign reload = (period == '0) ? '0 : period - DIV_W'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    rem_d   = rem_q;
    div_d   = div_q;
    done_d  = 1'b0;
    motor_d = energize ? coil(phase_q) : 4'b0000;
    step    = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (!abort) begin
          if (move_start) begin
            if (move_steps == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = MOVE;
              rem_d   = move_steps;
              div_d   = reload;
            end
          end else if (run) begin
            state_d = JOG;
            div_d   = reload;
          end
        end
      end
      JOG: begin
        if (abort || !run) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (div_q == '0) begin
          step  = 1'b1;
          div_d = reload;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      MOVE: begin
        if (abort) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (div_q == '0) begin
          step  = 1'b1;
          div_d = reload;
          rem_d = rem_q - POS_W'(1);
          if (rem_q == POS_W'(1)) begin
            state_d = IDLE;
            div_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase

    // Full-step settles on odd phases, wave on even; half always moves one.
    case (mode)
      2'b01:   delta = phase_q[0] ? 3'd2 : 3'd1;
      2'b10:   delta = phase_q[0] ? 3'd1 : 3'd2;
      default: delta = 3'd1;
    endcase

    if (step) begin
      phase_d = dir ? phase_q + delta : phase_q - delta;
      pos_d   = dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 3'd0;
      pos_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      motor_q <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      motor_q <= motor_d;
      done_q  <= done_d;
    end
  end

  assign motor    = motor_q;
  assign position = pos_q;
  assign busy     = (state_q == MOVE);
  assign done     = done_q;

endmodule

// File: tb/tb_stepper_drive.sv
// Scoreboard bench for stepper_drive: a cycle-level reference model schedules
// steps by absolute clock time and queues the expected outputs per edge.
module tb_stepper_drive;
  localparam int DIV_W = 16;
  localparam int POS_W = 16;

  logic             clk = 1'b0;
  logic             rst, run, dir, energize, move_start, abort;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic [POS_W-1:0] move_steps;
  logic [3:0]       motor;
  logic [POS_W-1:0] position;
  logic             busy, done;

  stepper_drive #(.DIV_W(DIV_W), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .mode(mode), .period(period),
    .energize(energize), .move_start(move_start), .move_steps(move_steps),
    .abort(abort), .motor(motor), .position(position), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       motor;
    logic [POS_W-1:0] pos;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: step times are absolute cycle numbers.
  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int    m_state = 0;  // 0 idle, 1 jog, 2 move
  int    m_phase = 0;
  int    m_pos   = 0;
  int    m_rem   = 0;
  longint cyc    = 0;
  longint m_next = 0;

  function automatic exp_t model_edge();
    exp_t e;
    int per, d;
    bit stp;
    logic [31:0] pv;
    per = (period == 0) ? 1 : int'(period);
    cyc++;
    stp = 0;
    if (rst) begin
      m_state = 0; m_phase = 0; m_pos = 0; m_rem = 0;
      return '0;
    end
    e.motor = energize ? tbl[m_phase] : 4'b0000;
    e.done  = 1'b0;
    if (abort) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (move_start) begin
        if (move_steps == 0) e.done = 1'b1;
        else begin m_state = 2; m_rem = int'(move_steps); m_next = cyc + per; end
      end else if (run) begin
        m_state = 1; m_next = cyc + per;
      end
    end else if (m_state == 1 && !run) begin
      m_state = 0;
    end else if (cyc == m_next) begin
      stp = 1;
      m_next = cyc + per;
      if (m_state == 2) begin
        m_rem--;
        if (m_rem == 0) begin m_state = 0; e.done = 1'b1; end
      end
    end
    if (stp) begin
      if (mode == 2'b01)      d = (m_phase % 2 == 1) ? 2 : 1;
      else if (mode == 2'b10) d = (m_phase % 2 == 0) ? 2 : 1;
      else                    d = 1;
      m_phase = dir ? (m_phase + d) % 8 : (m_phase + 8 - d) % 8;
      m_pos   = dir ? m_pos + 1 : m_pos - 1;
    end
    pv     = m_pos;
    e.pos  = pv[POS_W-1:0];
    e.busy = (m_state == 2);
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    e = model_edge();
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if ({motor, position, busy, done} !== e) begin
        bad++;
        $display("FAIL cycle%0d: motor=%b pos=%0d busy=%b done=%b, expected motor=%b pos=%0d busy=%b done=%b",
                 cyc, motor, $signed(position), busy, done,
                 e.motor, $signed(e.pos), e.busy, e.done);
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    total++;
    if ({motor, position, busy, done} !== '0) begin
      bad++;
      $display("FAIL %s: motor=%b pos=%0d busy=%b done=%b, expected all zero",
               name, motor, position, busy, done);
    end
  endtask

  // Asserts rst between edges and checks the outputs clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst = 1'b0;
  endtask

  task automatic start_move(input int n);
    move_steps = POS_W'(n);
    move_start = 1'b1;
    tick();
    move_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 0; dir = 1; energize = 1; move_start = 0; abort = 0;
    mode = 2'b00; period = 4; move_steps = 0;
    #3;
    check_reset_outputs("reset_state");
    repeat (2) tick();
    rst = 1'b0;

    // Half-step jog forward through a full wrap
    run = 1;
    repeat (36) tick();
    run = 0;
    repeat (2) tick();

    // Full-step counted move in reverse from phase 0
    async_reset();
    mode = 2'b01; dir = 0; period = 2;
    start_move(3);
    repeat (9) tick();

    // Wave move forward from phase 3
    mode = 2'b10; dir = 1; period = 3;
    start_move(2);
    repeat (9) tick();

    // Abort right after the second step of a 5-step move
    async_reset();
    mode = 2'b00; dir = 1; period = 2;
    start_move(5);
    repeat (4) tick();
    abort = 1;
    tick();
    abort = 0;
    repeat (4) tick();

    // Zero-length move, then period 0 jog
    start_move(0);
    repeat (2) tick();
    period = 0; run = 1;
    repeat (6) tick();

    // De-energized jog still advances
    energize = 0;
    repeat (6) tick();
    energize = 1;
    run = 0;
    repeat (2) tick();

    // Reset in the middle of a move
    period = 1;
    start_move(10);
    repeat (3) tick();
    async_reset();
    repeat (3) tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0)  dir = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) period = DIV_W'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) energize = ($urandom_range(0, 3) != 0);
      move_start = ($urandom_range(0, 9) == 0);
      move_steps = POS_W'($urandom_range(0, 6));
      abort      = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end
    move_start = 0; abort = 0;
    repeat (2) tick();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
